// File: rtl/riscv_pkg.sv
// Shared RISC-V constants and the load-tag layout used by the writeback stage.
package riscv_pkg;
  localparam int REG_W    = 5;
  localparam int XLEN_DEF = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [2:0]       funct3;
    logic [1:0]       addr_lo;
  } ld_tag_t;
endpackage

// File: rtl/writeback_unit_load_align.sv
// Combinational load formatter: shifts the raw word by the byte offset, then
// sign/zero extends according to funct3 and flags reserved or misaligned forms.
module load_align
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] value,
  output logic            fmt_err
);
  logic [XLEN-1:0] w_shift;

  assign w_shift = rdata >> {addr_lo, 3'b000};

  always_comb begin
    value   = w_shift;
    fmt_err = 1'b0;
    case (funct3)
      F3_LB:  value = {{(XLEN-8){w_shift[7]}}, w_shift[7:0]};
      F3_LBU: value = {{(XLEN-8){1'b0}}, w_shift[7:0]};
      F3_LH: begin
        value   = {{(XLEN-16){w_shift[15]}}, w_shift[15:0]};
        fmt_err = (addr_lo == 2'd3);
      end
      F3_LHU: begin
        value   = {{(XLEN-16){1'b0}}, w_shift[15:0]};
        fmt_err = (addr_lo == 2'd3);
      end
      F3_LW: fmt_err = (addr_lo != 2'd0);
      // Reserved encodings still write the full shifted word.
      default: fmt_err = 1'b1;
    endcase
  end
endmodule

// File: rtl/writeback_unit.sv
// Final pipeline stage owning the register-file write port; merges ALU results
// with in-order load responses tracked by a small pending-load tag queue.
module writeback_unit
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [REG_W-1:0]       alu_rd,
  input  logic [XLEN-1:0]        alu_result,
  input  logic                   ld_issue_valid,
  output logic                   ld_issue_ready,
  input  logic [REG_W-1:0]       ld_rd,
  input  logic [2:0]             ld_funct3,
  input  logic [1:0]             ld_addr_lo,
  input  logic                   mem_rvalid,
  input  logic [XLEN-1:0]        mem_rdata,
  output logic [REG_W-1:0]       dstreg_num,
  output logic [XLEN-1:0]        write_value,
  output logic                   reg_we,
  output logic [31:0]            busy_mask,
  output logic [$clog2(DEPTH):0] pending_count,
  output logic                   err
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  ld_tag_t          r_q [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_err;
  logic             r_reg_we;
  logic [REG_W-1:0] r_dst;
  logic [XLEN-1:0]  r_val;

  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_alu_acc;
  ld_tag_t          w_head;
  ld_tag_t          w_new_tag;
  logic [XLEN-1:0]  w_ld_value;
  logic             w_fmt_err;
  logic [31:0]      w_busy;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == FULL_CNT);
  assign w_head    = r_q[r_rd_ptr];
  assign w_new_tag = '{rd: ld_rd, funct3: ld_funct3, addr_lo: ld_addr_lo};

  assign ld_issue_ready = !w_full;
  assign alu_ready      = !(mem_rvalid && !w_empty) && !rst;
  assign w_push         = ld_issue_valid && !w_full;
  assign w_pop          = mem_rvalid && !w_empty;
  assign w_alu_acc      = alu_valid && alu_ready;

  load_align #(.XLEN(XLEN)) u_align (
    .funct3  (w_head.funct3),
    .addr_lo (w_head.addr_lo),
    .rdata   (mem_rdata),
    .value   (w_ld_value),
    .fmt_err (w_fmt_err)
  );

  // Tag storage carries no reset; validity comes from the pointers and count.
  always_ff @(posedge clk) begin
    if (!rst && w_push) r_q[r_wr_ptr] <= w_new_tag;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
      r_reg_we <= 1'b0;
      r_dst    <= '0;
      r_val    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if ((mem_rvalid && w_empty) || (w_pop && w_fmt_err)) r_err <= 1'b1;

      // Load responses win the write port; x0 writes are consumed silently.
      r_reg_we <= 1'b0;
      if (w_pop) begin
        if (w_head.rd != '0) begin
          r_reg_we <= 1'b1;
          r_dst    <= w_head.rd;
          r_val    <= w_ld_value;
        end
      end else if (w_alu_acc && (alu_rd != '0)) begin
        r_reg_we <= 1'b1;
        r_dst    <= alu_rd;
        r_val    <= alu_result;
      end
    end
  end

  always_comb begin
    w_busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((PTR_W+1)'(i) < r_count) begin
        if (r_q[r_rd_ptr + PTR_W'(i)].rd != '0)
          w_busy[r_q[r_rd_ptr + PTR_W'(i)].rd] = 1'b1;
      end
    end
  end

  assign busy_mask     = w_busy;
  assign pending_count = r_count;
  assign err           = r_err;
  assign reg_we        = r_reg_we;
  assign dstreg_num    = r_dst;
  assign write_value   = r_val;
endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Final pipeline stage that owns the single register-file write port: drives dstreg_num, write_value and reg_we into the register file.
- Merges two sources:
  - ALU results, through a valid/ready handshake.
  - In-order memory load responses, matched against a small queue of pending load tags, then byte/halfword aligned and sign/zero extended.
- Exports a per-register busy mask so decode can stall on registers with a pending load.

Parameters:
- DEPTH, 4, pending-load queue entries (power of two, ≥2)
- XLEN, 32, data width

Ports:
- clk  in  1  clock, all state on posedge
- rst  in  1  synchronous active-high reset
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU result accepted this cycle when valid&&ready
- alu_rd  in  5  ALU destination register
- alu_result  in  XLEN  ALU result
- ld_issue_valid  in  1  load issued to memory
- ld_issue_ready  out  1  queue can take a tag
- ld_rd  in  5  load destination register
- ld_funct3  in  3  RISC-V load funct3
- ld_addr_lo  in  2  byte offset of load address
- mem_rvalid  in  1  load data returns this cycle (in issue order)
- mem_rdata  in  XLEN  raw aligned word from memory
- dstreg_num  out  5  register-file write index
- write_value  out  XLEN  register-file write data
- reg_we  out  1  register-file write enable
- busy_mask  out  32  bit r set while any queued load targets r
- pending_count  out  log2(DEPTH)+1  queued loads
- err  out  1  sticky protocol/format error

Behaviour:
- Reset:
  - Queue emptied; pending_count=0, busy_mask=0, err=0.
  - dstreg_num=0, write_value=0, reg_we=0.
  - Inputs in a reset cycle are ignored, including mem_rvalid and ld_issue_valid.
- Queue:
  - Circular FIFO of {rd, funct3, addr_lo}.
  - ld_issue_ready = !full, with no pass-through when full.
  - Push on ld_issue_valid&&ld_issue_ready.
  - Pop on mem_rvalid with the queue non-empty.
  - Push and pop in the same cycle: both happen, count unchanged.
  - Pointers wrap modulo DEPTH.
- mem_rvalid with an empty queue: response dropped, err set.
- Write-port arbitration:
  - A load response has priority.
  - alu_ready = !(mem_rvalid && queue non-empty) && !rst.
  - An ALU result is never dropped, only held off.
- Write latency:
  - An accepted event is registered; reg_we, dstreg_num and write_value are valid on the next posedge (1-cycle latency).
  - reg_we=0 in any cycle following no accepted event.
  - dstreg_num and write_value hold their previous values when reg_we=0.
- rd==0:
  - The event is still accepted (and a load is still popped).
  - reg_we stays 0.
  - A load with ld_rd==0 is not marked busy.
- Load alignment, with s = mem_rdata >> (8*addr_lo):
  - LB 000: sext s[7:0]
  - LH 001: sext s[15:0]
  - LW 010: s
  - LBU 100: zext s[7:0]
  - LHU 101: zext s[15:0]
  - Reserved funct3 (011, 110, 111): treated as LW, err set.
  - Misaligned (LH/LHU with addr_lo==3, LW with addr_lo!=0): the value computed from s is written and err is set.
- busy_mask:
  - Combinational OR of one-hot(rd) over valid queue entries.
  - Clears the cycle after the last entry for that rd pops.
  - A second load to the same rd keeps the bit set until both pop.
- err: sticky until rst.

Decomposition:
- Shared package riscv_pkg:
  - funct3 load constants LB/LH/LW/LBU/LHU.
  - Register-index width 5 and XLEN.
  - Struct/concatenation layout of a load tag.
- Sub-module load_align (combinational): inputs funct3, addr_lo, rdata; outputs value, fmt_err.
- The queue lives inline in writeback_unit.

Test Plan:
- ALU only: alu_valid=1, rd=5, result=0xDEADBEEF -> alu_ready=1; next cycle reg_we=1, dstreg_num=5, write_value=0xDEADBEEF.
- Collision: load tag rd=3 LB addr_lo=1 queued; mem_rvalid=1, rdata=0x0000_8000 with ALU rd=7 valid in the same cycle -> alu_ready=0; next cycle write rd=3 value=0xFFFF_FF80; ALU rd=7 written the cycle after.
- Queue full: 4 issues with no response -> ld_issue_ready=0, pending_count=4, busy_mask marks all four rds; simultaneous issue+response at count=2 -> count stays 2.
- Format/alignment: LHU addr_lo=2, rdata=0xABCD_1234 -> 0x0000_ABCD, err=0; LW addr_lo=1 -> err=1 and stays 1.
- rd=0 and empty pop: ALU rd=0 -> reg_we=0; mem_rvalid with empty queue -> no write, err=1.
- Reset mid-operation: 3 loads queued, rst=1 for one cycle with mem_rvalid=1 -> no write; pending_count=0, busy_mask=0, reg_we=0, err=0.
